// File: rtl/ifu_fetch.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// ifu_fetch
//
// Instruction-fetch stage. It holds the PC, fetches one instruction word at a
// time from instruction memory over a req/ack handshake, and presents the
// word to the decode/extend stage. When decode consumes the word, the next
// fetch address is chosen from the sequential PC or from a redirect (branch,
// J/JAL, JR) supplied by the retiring instruction.
//
// Optional feature (macro IFU_MISALIGN_CHK_EN):
//   defined   - a computed next fetch address with bits [1:0] != 0 sets the
//               sticky fetch_err flag and parks the FSM in IDLE (no request)
//               until reset.
//   undefined - fetch_err is tied to 0 and addresses pass through unmodified.
//
// Ports:
//   clk           in   system clock, rising edge
//   rst           in   asynchronous, active-high reset
//   imem_req      out  fetch request to instruction memory
//   imem_addr     out  fetch byte address, stable while imem_req=1
//   imem_ack      in   memory returns imem_rdata this cycle
//   imem_rdata    in   returned instruction word
//   ins           out  instruction register to decoder/extender
//   pc            out  address of the word held in ins
//   ins_valid     out  ins/pc hold a fetched, unconsumed instruction
//   ins_ready     in   downstream consumes ins this cycle
//   redir_valid   in   retiring instruction changes control flow
//   redir_type    in   00 branch, 01 J/JAL, 10 JR, 11 none
//   redir_offset  in   branch byte offset (already shifted and extended)
//   redir_reg     in   JR target register value
//   fetch_err     out  misaligned-target flag (optional feature)
// ---------------------------------------------------------------------------
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ins,
  output logic [31:0] pc,
  output logic        ins_valid,
  input  logic        ins_ready,
  input  logic        redir_valid,
  input  logic [1:0]  redir_type,
  input  logic [31:0] redir_offset,
  input  logic [31:0] redir_reg,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    HOLD  = 2'b10
  } state_t;

  localparam logic [1:0] REDIR_BRANCH = 2'b00;
  localparam logic [1:0] REDIR_JUMP   = 2'b01;
  localparam logic [1:0] REDIR_JR     = 2'b10;

  state_t      state_q;
  logic [31:0] fetch_addr_q;
  logic [31:0] pc_q;
  logic [31:0] ins_q;
  logic        ins_valid_q;
  logic        imem_req_q;

  logic [31:0] next_addr_d;
  logic        misalign_d;
  logic        accept_d;

  // Next fetch address for the instruction currently held in ins/pc.
  // All arithmetic wraps modulo 2^32; the branch offset is two's complement,
  // so a plain add gives the signed displacement.
  function automatic logic [31:0] next_fetch(
    input logic [31:0] cur_pc,
    input logic [31:0] cur_ins,
    input logic        rvld,
    input logic [1:0]  rtype,
    input logic [31:0] roff,
    input logic [31:0] rreg
  );
    logic signed [31:0] off_s;
    logic        [31:0] pc4;
    pc4   = cur_pc + 32'd4;
    off_s = signed'(roff);
    next_fetch = pc4;
    if (rvld) begin
      case (rtype)
        REDIR_BRANCH: next_fetch = pc4 + unsigned'(off_s);
        REDIR_JUMP:   next_fetch = {pc4[31:28], cur_ins[25:0], 2'b00};
        REDIR_JR:     next_fetch = rreg;
        default:      next_fetch = pc4;
      endcase
    end
  endfunction

  // Redirect information is only meaningful on the cycle decode consumes ins.
  assign accept_d    = (state_q == HOLD) && ins_ready;
  assign next_addr_d = next_fetch(pc_q, ins_q, redir_valid, redir_type,
                                  redir_offset, redir_reg);

`ifdef IFU_MISALIGN_CHK_EN
  logic fetch_err_q;

  assign misalign_d = |next_addr_d[1:0];

  // Sticky error flag; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_err_q <= 1'b0;
    end else if (accept_d && misalign_d) begin
      fetch_err_q <= 1'b1;
    end
  end

  assign fetch_err = fetch_err_q;
`else
  assign misalign_d = 1'b0;
  assign fetch_err  = 1'b0;
`endif

  // Fetch FSM with registered outputs. imem_addr is the fetch address
  // register itself, so it cannot change while a request is outstanding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      fetch_addr_q <= RESET_PC;
      pc_q         <= RESET_PC;
      ins_q        <= 32'h0;
      ins_valid_q  <= 1'b0;
      imem_req_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // A latched fetch error parks the FSM here until reset.
          if (!fetch_err) begin
            state_q    <= FETCH;
            imem_req_q <= 1'b1;
          end
        end

        FETCH: begin
          if (imem_ack) begin
            ins_q       <= imem_rdata;
            pc_q        <= fetch_addr_q;
            ins_valid_q <= 1'b1;
            imem_req_q  <= 1'b0;
            state_q     <= HOLD;
          end
        end

        HOLD: begin
          if (accept_d) begin
            fetch_addr_q <= next_addr_d;
            ins_valid_q  <= 1'b0;
            if (misalign_d) begin
              state_q    <= IDLE;
              imem_req_q <= 1'b0;
            end else begin
              state_q    <= FETCH;
              imem_req_q <= 1'b1;
            end
          end
        end

        default: begin
          state_q     <= IDLE;
          imem_req_q  <= 1'b0;
          ins_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req  = imem_req_q;
  assign imem_addr = fetch_addr_q;
  assign ins       = ins_q;
  assign pc        = pc_q;
  assign ins_valid = ins_valid_q;

endmodule

// File: tb/tb_ifu_fetch.sv
`timescale 1ns/1ps
// Directed bench for ifu_fetch: handshake timing, HOLD stability, every
// redirect type, reset during FETCH and HOLD, and the misaligned-JR case.
module tb_ifu_fetch;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] ins;
  logic [31:0] pc;
  logic        ins_valid;
  logic        ins_ready;
  logic        redir_valid;
  logic [1:0]  redir_type;
  logic [31:0] redir_offset;
  logic [31:0] redir_reg;
  logic        fetch_err;

  int tests;
  int fails;

  ifu_fetch #(.RESET_PC(32'h0040_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .ins          (ins),
    .pc           (pc),
    .ins_valid    (ins_valid),
    .ins_ready    (ins_ready),
    .redir_valid  (redir_valid),
    .redir_type   (redir_type),
    .redir_offset (redir_offset),
    .redir_reg    (redir_reg),
    .fetch_err    (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory returns one word on the current request.
  task automatic fetch(input logic [31:0] word);
    imem_ack   = 1'b1;
    imem_rdata = word;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
  endtask

  // Decode consumes ins with the given redirect information.
  task automatic accept(input logic rv, input logic [1:0] rt,
                        input logic [31:0] off, input logic [31:0] rg);
    ins_ready    = 1'b1;
    redir_valid  = rv;
    redir_type   = rt;
    redir_offset = off;
    redir_reg    = rg;
    tick();
    ins_ready    = 1'b0;
    redir_valid  = 1'b0;
    redir_type   = 2'b11;
    redir_offset = 32'h0;
    redir_reg    = 32'h0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    imem_ack = 1'b0;
    imem_rdata = 32'h0;
    ins_ready = 1'b0;
    redir_valid = 1'b0;
    redir_type = 2'b11;
    redir_offset = 32'h0;
    redir_reg = 32'h0;

    tick();
    tick();
    chk("rst_req",   {31'h0, imem_req},  32'h0);
    chk("rst_addr",  imem_addr,          32'h0040_0000);
    chk("rst_pc",    pc,                 32'h0040_0000);
    chk("rst_ins",   ins,                32'h0);
    chk("rst_valid", {31'h0, ins_valid}, 32'h0);
    chk("rst_err",   {31'h0, fetch_err}, 32'h0);

    // Reset release: one IDLE cycle, then the first request.
    rst = 1'b0;
    tick();
    chk("first_req",  {31'h0, imem_req}, 32'h1);
    chk("first_addr", imem_addr,         32'h0040_0000);
    fetch(32'h2008_0005);
    chk("first_ins",   ins,                32'h2008_0005);
    chk("first_pc",    pc,                 32'h0040_0000);
    chk("first_valid", {31'h0, ins_valid}, 32'h1);
    chk("first_req_drop", {31'h0, imem_req}, 32'h0);

    // HOLD with no consumer and spurious acks.
    for (int i = 0; i < 5; i++) begin
      imem_ack   = (i % 2 == 0);
      imem_rdata = 32'hFFFF_FFFF;
      tick();
    end
    imem_ack = 1'b0;
    chk("hold_ins",   ins,                32'h2008_0005);
    chk("hold_pc",    pc,                 32'h0040_0000);
    chk("hold_req",   {31'h0, imem_req},  32'h0);
    chk("hold_valid", {31'h0, ins_valid}, 32'h1);

    accept(1'b0, 2'b00, 32'h0, 32'h0);
    chk("seq_addr",  imem_addr,          32'h0040_0004);
    chk("seq_req",   {31'h0, imem_req},  32'h1);
    chk("seq_valid", {31'h0, ins_valid}, 32'h0);

    // Redirect presented during FETCH must be ignored.
    redir_valid = 1'b1;
    redir_type  = 2'b10;
    redir_reg   = 32'h1234_5678;
    tick();
    tick();
    redir_valid = 1'b0;
    chk("fetch_redir_ignored", imem_addr, 32'h0040_0004);

    fetch(32'h0000_0000);
    chk("pc_0004", pc, 32'h0040_0004);
    accept(1'b1, 2'b11, 32'h0000_1000, 32'h0000_2000);
    chk("type11_addr", imem_addr, 32'h0040_0008);

    fetch(32'h0810_0040);
    chk("jump_pc", pc, 32'h0040_0008);
    accept(1'b1, 2'b01, 32'h0, 32'h0);
    chk("jump_addr", imem_addr, 32'h0040_0100);

    fetch(32'h0000_0000);
    accept(1'b1, 2'b10, 32'h0, 32'h0040_0010);
    chk("jr_0010", imem_addr, 32'h0040_0010);
    fetch(32'h1000_FFFC);
    chk("br_pc", pc, 32'h0040_0010);
    accept(1'b1, 2'b00, 32'hFFFF_FFF0, 32'h0);
    chk("br_back", imem_addr, 32'h0040_0004);

    fetch(32'h0000_0000);
    accept(1'b1, 2'b10, 32'h0, 32'h0040_0010);
    fetch(32'h1000_0008);
    accept(1'b1, 2'b00, 32'h0000_0020, 32'h0);
    chk("br_fwd", imem_addr, 32'h0040_0034);

    fetch(32'h0000_0000);
    accept(1'b1, 2'b10, 32'h0, 32'h0040_0200);
    chk("jr_0200", imem_addr, 32'h0040_0200);

    // Reset while a request is out and memory acks in the same cycle.
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    rst        = 1'b1;
    #1;
    chk("rstf_req_now",   {31'h0, imem_req},  32'h0);
    chk("rstf_valid_now", {31'h0, ins_valid}, 32'h0);
    tick();
    chk("rstf_ins",   ins,                32'h0);
    chk("rstf_valid", {31'h0, ins_valid}, 32'h0);
    rst      = 1'b0;
    imem_ack = 1'b0;
    tick();
    chk("rstf_addr", imem_addr,         32'h0040_0000);
    chk("rstf_req",  {31'h0, imem_req}, 32'h1);

    // Reset while holding an instruction.
    fetch(32'h2008_0005);
    chk("rsth_valid_pre", {31'h0, ins_valid}, 32'h1);
    rst = 1'b1;
    #1;
    chk("rsth_valid_now", {31'h0, ins_valid}, 32'h0);
    rst = 1'b0;
    tick();
    chk("rsth_addr", imem_addr,         32'h0040_0000);
    chk("rsth_req",  {31'h0, imem_req}, 32'h1);

    // Misaligned JR target.
    fetch(32'h0000_0000);
    accept(1'b1, 2'b10, 32'h0, 32'h0040_0202);
`ifdef IFU_MISALIGN_CHK_EN
    chk("mis_err", {31'h0, fetch_err}, 32'h1);
    chk("mis_req", {31'h0, imem_req},  32'h0);
    tick();
    tick();
    tick();
    chk("mis_err_sticky", {31'h0, fetch_err}, 32'h1);
    chk("mis_req_held",   {31'h0, imem_req},  32'h0);
`else
    chk("mis_addr", imem_addr,          32'h0040_0202);
    chk("mis_req",  {31'h0, imem_req},  32'h1);
    chk("mis_err",  {31'h0, fetch_err}, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
